// File: rtl/sram_like_arbiter_if.sv
// SRAM-like request/response bundle: one instance per requester and one for memory.
// master drives the request side; slave accepts it and returns the handshakes and read data.
interface sram_like_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [DW-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between fetch (I) and data (D), one transaction in flight.
// Grant is combinational in IDLE; D wins unless I has waited through STARVE_MAX D grants.
module sram_like_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_like_arbiter_if.slave   i_bus,
    sram_like_arbiter_if.slave   d_bus,
    sram_like_arbiter_if.master  m_bus,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_owner;
    logic [3:0] r_starve_cnt;

    logic w_starving;
    logic w_any_req;
    logic w_sel_d;
    logic w_gnt_d;
    logic w_m_req;
    logic w_accept;
    logic w_resp;

    always_comb begin
        w_starving = i_bus.req && (r_starve_cnt >= 4'(STARVE_MAX));
        w_any_req  = i_bus.req || d_bus.req;
        w_sel_d    = d_bus.req && !w_starving;
        w_gnt_d    = (r_state == IDLE) ? w_sel_d : r_owner;
        // Reset gates the IDLE pass-through so outputs read 0 while reset is held.
        w_m_req    = !reset && (((r_state == IDLE) && w_any_req) || (r_state == ADDR));
        w_accept   = w_m_req && m_bus.addr_ok;
        w_resp     = !reset && (r_state == DATA) && m_bus.data_ok;
    end

    always_comb begin
        m_bus.req   = w_m_req;
        m_bus.wr    = 1'b0;
        m_bus.size  = 2'd0;
        m_bus.addr  = '0;
        m_bus.wdata = '0;
        if (!reset) begin
            m_bus.wr    = w_gnt_d ? d_bus.wr    : i_bus.wr;
            m_bus.size  = w_gnt_d ? d_bus.size  : i_bus.size;
            m_bus.addr  = w_gnt_d ? d_bus.addr  : i_bus.addr;
            m_bus.wdata = w_gnt_d ? d_bus.wdata : i_bus.wdata;
        end
    end

    always_comb begin
        i_bus.addr_ok = w_accept && !w_gnt_d;
        d_bus.addr_ok = w_accept &&  w_gnt_d;
        i_bus.data_ok = w_resp && !r_owner;
        d_bus.data_ok = w_resp &&  r_owner;
        i_bus.rdata   = i_bus.data_ok ? m_bus.rdata : '0;
        d_bus.rdata   = d_bus.data_ok ? m_bus.rdata : '0;
        busy          = (r_state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_starve_cnt <= 4'd0;
        end else begin
            if (w_accept) begin
                if (!w_gnt_d) begin
                    r_starve_cnt <= 4'd0;
                end else if (i_bus.req && (r_starve_cnt != 4'd15)) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_sel_d;
                        r_state <= m_bus.addr_ok ? DATA : ADDR;
                    end
                end
                // Owner stays locked here; a coincident data_ok is not a response.
                ADDR: begin
                    if (m_bus.addr_ok) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (m_bus.data_ok) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized and directed bench for sram_like_arbiter against a transaction-level model.
module tb_sram_like_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int STARVE_MAX = 4;

    logic clk;
    logic reset;
    logic busy;

    sram_like_arbiter_if #(.AW(AW), .DW(DW)) ibus ();
    sram_like_arbiter_if #(.AW(AW), .DW(DW)) dbus ();
    sram_like_arbiter_if #(.AW(AW), .DW(DW)) mbus ();

    sram_like_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .i_bus (ibus.slave),
        .d_bus (dbus.slave),
        .m_bus (mbus.master),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Model: phase 0 = nothing open, 1 = granted but not yet accepted, 2 = awaiting response.
    int mph  = 0;
    int mown = 0;
    int mcnt = 0;

    bit last_iaok, last_daok;
    logic          obs_iaok, obs_daok, obs_idok, obs_ddok, obs_busy, obs_mreq, obs_mwr;
    logic [AW-1:0] obs_maddr;
    logic [DW-1:0] obs_irdata, obs_drdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_quiet();
        ibus.req = 0; ibus.wr = 0; ibus.size = 0; ibus.addr = 0; ibus.wdata = 0;
        dbus.req = 0; dbus.wr = 0; dbus.size = 0; dbus.addr = 0; dbus.wdata = 0;
        mbus.addr_ok = 0; mbus.data_ok = 0; mbus.rdata = 0;
    endtask

    task automatic model_reset();
        mph = 0; mown = 0; mcnt = 0;
    endtask

    // Called at posedge+1 with inputs driven; checks at mid-cycle, returns at next posedge+1.
    task automatic step();
        int  g;
        bit  starving, e_mreq, e_iaok, e_daok, e_idok, e_ddok;
        #4;
        starving = ibus.req && (mcnt >= STARVE_MAX);
        g = mown;
        e_mreq = 0;
        if (mph == 0) begin
            e_mreq = ibus.req || dbus.req;
            g = (dbus.req && !starving) ? 1 : 0;
        end else if (mph == 1) begin
            e_mreq = 1;
        end
        e_iaok = mbus.addr_ok && e_mreq && (g == 0);
        e_daok = mbus.addr_ok && e_mreq && (g == 1);
        e_idok = (mph == 2) && mbus.data_ok && (mown == 0);
        e_ddok = (mph == 2) && mbus.data_ok && (mown == 1);

        obs_iaok = ibus.addr_ok; obs_daok = dbus.addr_ok;
        obs_idok = ibus.data_ok; obs_ddok = dbus.data_ok;
        obs_irdata = ibus.rdata; obs_drdata = dbus.rdata;
        obs_busy = busy; obs_mreq = mbus.req; obs_mwr = mbus.wr; obs_maddr = mbus.addr;

        chk("m_req", obs_mreq, e_mreq);
        chk("i_addr_ok", obs_iaok, e_iaok);
        chk("d_addr_ok", obs_daok, e_daok);
        chk("i_data_ok", obs_idok, e_idok);
        chk("d_data_ok", obs_ddok, e_ddok);
        chk("i_rdata", obs_irdata, e_idok ? mbus.rdata : '0);
        chk("d_rdata", obs_drdata, e_ddok ? mbus.rdata : '0);
        chk("busy", obs_busy, mph != 0);
        if (e_mreq) begin
            chk("m_wr",    mbus.wr,    (g == 1) ? dbus.wr    : ibus.wr);
            chk("m_size",  mbus.size,  (g == 1) ? dbus.size  : ibus.size);
            chk("m_addr",  mbus.addr,  (g == 1) ? dbus.addr  : ibus.addr);
            chk("m_wdata", mbus.wdata, (g == 1) ? dbus.wdata : ibus.wdata);
        end

        if (e_mreq && mbus.addr_ok) begin
            mown = g;
            mph  = 2;
            if (g == 0)       mcnt = 0;
            else if (ibus.req) mcnt = (mcnt < 15) ? mcnt + 1 : 15;
        end else if (e_mreq) begin
            mown = g;
            mph  = 1;
        end else if ((mph == 2) && mbus.data_ok) begin
            mph = 0;
        end
        last_iaok = e_iaok;
        last_daok = e_daok;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ihold, dhold;
        int dgr;
        bit igr;

        drive_quiet();
        reset = 1'b1;
        #3;
        chk("rst_m_req", mbus.req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_aok", {ibus.addr_ok, dbus.addr_ok, ibus.data_ok, dbus.data_ok}, 0);
        chk("rst_m_fields", {mbus.wr, mbus.size, mbus.addr, mbus.wdata}, 0);
        chk("rst_rdata", {ibus.rdata, dbus.rdata}, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_reset();

        // Solo fetch
        ibus.req = 1; ibus.addr = 32'hBFC0_0000; ibus.size = 2; mbus.addr_ok = 1;
        step();
        chk("solo_i_aok", obs_iaok, 1);
        chk("solo_busy0", obs_busy, 0);
        chk("solo_maddr", obs_maddr, 32'hBFC0_0000);
        ibus.req = 0; mbus.addr_ok = 0; mbus.data_ok = 1; mbus.rdata = 32'h3C08_0001;
        step();
        chk("solo_i_dok", obs_idok, 1);
        chk("solo_i_rdata", obs_irdata, 32'h3C08_0001);
        chk("solo_busy1", obs_busy, 1);
        chk("solo_d_quiet", {obs_daok, obs_ddok, obs_drdata}, 0);
        drive_quiet();
        step();
        chk("solo_busy2", obs_busy, 0);

        // Simultaneous: D first, then I
        ibus.req = 1; ibus.addr = 32'hBFC0_0004; ibus.size = 2;
        dbus.req = 1; dbus.wr = 1; dbus.addr = 32'h8000_1000; dbus.wdata = 32'h1234_5678; dbus.size = 2;
        mbus.addr_ok = 1;
        step();
        chk("sim_d_first", obs_daok, 1);
        chk("sim_m_wr", obs_mwr, 1);
        chk("sim_m_addr", obs_maddr, 32'h8000_1000);
        dbus.req = 0; mbus.addr_ok = 0; mbus.data_ok = 1;
        step();
        chk("sim_d_dok", obs_ddok, 1);
        mbus.addr_ok = 1; mbus.data_ok = 0;
        step();
        chk("sim_i_next", obs_iaok, 1);
        ibus.req = 0; mbus.addr_ok = 0; mbus.data_ok = 1;
        step();
        chk("sim_i_dok", obs_idok, 1);

        // Starvation: D stores back to back while I waits
        drive_quiet();
        ibus.req = 1; ibus.addr = 32'hBFC0_0100; ibus.size = 2;
        dbus.req = 1; dbus.wr = 1; dbus.size = 2;
        dgr = 0; igr = 0;
        for (int k = 0; k < 24 && !igr; k++) begin
            dbus.addr = 32'h8000_2000 + 32'(k * 4); dbus.wdata = $urandom;
            mbus.addr_ok = (mph != 2); mbus.data_ok = (mph == 2);
            step();
            if (obs_daok) dgr++;
            if (obs_iaok) igr = 1;
        end
        chk("starve_i_granted", igr, 1);
        chk("starve_d_grants", dgr, STARVE_MAX);
        ibus.req = 0; dbus.req = 0; mbus.addr_ok = 0; mbus.data_ok = 1;
        step();
        chk("starve_i_dok", obs_idok, 1);

        // Slow memory with D arriving mid-wait
        drive_quiet();
        ibus.req = 1; ibus.addr = 32'hBFC0_0200; ibus.size = 2;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin dbus.req = 1; dbus.addr = 32'h8000_3000; dbus.size = 2; end
            step();
            chk("slow_m_addr", obs_maddr, 32'hBFC0_0200);
            chk("slow_d_aok", obs_daok, 0);
        end
        mbus.addr_ok = 1;
        step();
        chk("slow_i_aok", obs_iaok, 1);
        ibus.req = 0; mbus.addr_ok = 1; mbus.data_ok = 1; mbus.rdata = 32'hCAFE_0001;
        step();
        chk("slow_i_dok", obs_idok, 1);
        chk("slow_d_held", obs_daok, 0);
        mbus.data_ok = 0;
        step();
        chk("slow_d_after", obs_daok, 1);
        dbus.req = 0; mbus.addr_ok = 0; mbus.data_ok = 1;
        step();

        // Stray response in IDLE
        drive_quiet();
        mbus.data_ok = 1; mbus.rdata = 32'hDEAD_BEEF;
        step();
        chk("stray_dok", {obs_idok, obs_ddok}, 0);
        mbus.data_ok = 0;
        step();
        chk("stray_idle", obs_busy, 0);

        // Async reset while in DATA
        ibus.req = 1; ibus.addr = 32'hBFC0_0300; mbus.addr_ok = 1;
        step();
        ibus.req = 0; mbus.addr_ok = 0;
        #1;
        chk("pre_rst_busy", busy, 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_m_req", mbus.req, 0);
        chk("mid_rst_hs", {ibus.addr_ok, dbus.addr_ok, ibus.data_ok, dbus.data_ok}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        mbus.data_ok = 1; mbus.rdata = 32'h0BAD_0BAD;
        step();
        chk("late_resp_dropped", {obs_idok, obs_ddok}, 0);

        // Randomized traffic
        drive_quiet();
        ihold = 0; dhold = 0; last_iaok = 0; last_daok = 0;
        for (int c = 0; c < 3000; c++) begin
            if (last_iaok) ihold = 0;
            if (last_daok) dhold = 0;
            if (!ihold) begin
                ibus.req = ($urandom_range(0, 2) == 0);
                ibus.wr = ($urandom_range(0, 7) == 0);
                ibus.size = 2'($urandom_range(0, 2));
                ibus.addr = $urandom; ibus.wdata = $urandom;
                ihold = ibus.req;
            end
            if (!dhold) begin
                dbus.req = ($urandom_range(0, 1) == 0);
                dbus.wr = 1'($urandom_range(0, 1));
                dbus.size = 2'($urandom_range(0, 2));
                dbus.addr = $urandom; dbus.wdata = $urandom;
                dhold = dbus.req;
            end
            mbus.addr_ok = 1'($urandom_range(0, 1));
            mbus.data_ok = ($urandom_range(0, 2) == 0);
            mbus.rdata = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one SRAM-like memory port between the CPU instruction requester (port I) and the data requester (port D).
- Sits between the core's fetch/mem stages and the single external memory bridge.
- Allows at most one outstanding transaction at a time.
- Uses fixed data-first priority with an anti-starvation counter for instruction fetch.
- Routes each response back to the requester that issued it.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_MAX, 4, consecutive D grants while I waits before I is forced to priority (range 1..15)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
i_req  in  1  instruction request valid
i_wr  in  1  instruction write flag (normally 0)
i_size  in  2  access size: 0=byte, 1=half, 2=word
i_addr  in  AW  instruction address
i_wdata  in  DW  instruction write data
i_addr_ok  out  1  request accepted for port I
i_data_ok  out  1  response for port I valid
i_rdata  out  DW  read data for port I
d_req, d_wr, d_size, d_addr, d_wdata  in  1/1/2/AW/DW  data-side equivalents of the I inputs
d_addr_ok, d_data_ok  out  1  data-side equivalents of the I handshakes
d_rdata  out  DW  read data for port D
m_req  out  1  shared-port request
m_wr  out  1  shared-port write flag
m_size  out  2  shared-port access size
m_addr  out  AW  shared-port address
m_wdata  out  DW  shared-port write data
m_addr_ok  in  1  memory accepted request
m_data_ok  in  1  memory response valid
m_rdata  in  DW  memory read data
busy  out  1  high whenever state is not IDLE

Behaviour:
- FSM states: IDLE, ADDR, DATA.
- Registers: owner (0=I, 1=D), starve_cnt (4 bits).
- Reset (async, reset=1):
  - state=IDLE, owner=0, starve_cnt=0.
  - All out ports 0: m_req, all addr_ok/data_ok, busy=0, m_* fields, rdata.
- Requester protocol: a requester holds req and all fields stable from assertion until it sees addr_ok. The arbiter does not check this.
- Grant selection in IDLE (combinational, same cycle):
  - sel = D if d_req && !(i_req && starve_cnt>=STARVE_MAX).
  - Otherwise sel = I if i_req.
  - Otherwise no request: m_req=0.
- m_req/m_wr/m_size/m_addr/m_wdata = fields of sel in IDLE, or of owner in ADDR. In DATA, m_req=0 and the fields hold owner's last values (don't care).
- x_addr_ok = m_addr_ok && m_req && (granted port == x). It is never asserted for the non-granted port.
- Transitions:
  - IDLE with request: owner<=sel. If m_addr_ok go to DATA, else go to ADDR.
  - ADDR: owner is locked until m_addr_ok, even if a higher-priority request appears. On m_addr_ok go to DATA.
  - DATA: no requests are forwarded. On m_data_ok:
    - assert owner's x_data_ok this cycle;
    - x_rdata = m_rdata (combinational passthrough);
    - return to IDLE.
  - Next grant earliest next cycle. Minimum turnaround is 2 cycles per transaction when the memory returns addr_ok and data_ok in consecutive cycles.
- x_rdata for the non-owner is 0. Both data_ok outputs are never high simultaneously.
- starve_cnt updates at each accepted grant (cycle where addr_ok is issued):
  - D granted while i_req=1: increment, saturating at 15.
  - I granted: clear to 0.
  - D granted while i_req=0: unchanged.
- m_data_ok in IDLE or ADDR (stray/late response) is ignored; no data_ok is produced.
- m_data_ok coincident with m_addr_ok in ADDR is treated as addr_ok only. Memory must not return data in the same cycle as address acceptance.
- Reset mid-transaction: FSM returns to IDLE immediately. Any later response from memory for the abandoned transaction is dropped per the stray rule.
- busy = (state != IDLE).

Test Plan:
- Solo fetch: i_req=1, addr=0xBFC00000, word read. Memory gives addr_ok in cycle 0 and data_ok with rdata=0x3C080001 in cycle 1 -> i_addr_ok in cycle 0, i_data_ok with i_rdata=0x3C080001 in cycle 1, d_* stay 0, busy=1 only in cycle 1.
- Simultaneous requests: i_req=d_req=1 with starve_cnt=0, d write of 0x12345678 to 0x80001000 size=2 -> D granted first (m_wr=1, m_addr=0x80001000). I is granted on the first IDLE cycle after d_data_ok. starve_cnt goes 0->1, then 0 after the I grant.
- Starvation: d_req held high for back-to-back stores while i_req=1, STARVE_MAX=4 -> 4 D grants, then the 5th grant goes to I despite d_req=1, and starve_cnt clears to 0.
- Slow memory: m_addr_ok delayed 3 cycles after I is granted, and d_req rises during the wait -> owner stays I, m_addr tracks i_addr for all 3 cycles, d_addr_ok stays 0 until after i_data_ok.
- Stray response: pulse m_data_ok in IDLE -> no data_ok outputs, state stays IDLE.
- Async reset mid-operation: assert reset in DATA state between clock edges -> busy, all handshakes and m_req go to 0 immediately. A later m_data_ok is ignored.
